// File: rtl/uart_tx.sv
// Serial transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity, one stop bit; each bit lasts Prescale clocks.
module uart_tx #(
  parameter int DATA_WIDTH    = 8,
  parameter int PRESCALE_BITS = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    P_DATA,
  input  logic                     Data_Valid,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  input  logic [PRESCALE_BITS-1:0] Prescale,
  output logic                     TX_OUT,
  output logic                     Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                   state, state_nxt;
  logic [PRESCALE_BITS-1:0] edge_cnt, edge_cnt_nxt, ps_reg, ps_last;
  logic [IDX_W-1:0]         bit_idx, bit_idx_nxt;
  logic [DATA_WIDTH-1:0]    data_reg;
  logic                     par_en_reg, par_typ_reg;
  logic                     bit_done, par_bit;
  logic                     tx_nxt, busy_nxt;

  // A latched Prescale of 0 is treated as a one-cycle bit.
  assign ps_last  = (ps_reg == '0) ? '0 : ps_reg - 1'b1;
  assign bit_done = (state != IDLE) && (edge_cnt == ps_last);
  assign par_bit  = (^data_reg) ^ par_typ_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Data_Valid) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && bit_idx == LAST_IDX)
                 state_nxt = par_en_reg ? PARITY : STOP;
      PARITY:  if (bit_done) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    edge_cnt_nxt = (state == IDLE || bit_done) ? '0 : edge_cnt + 1'b1;
    bit_idx_nxt  = '0;
    if (state == DATA)
      bit_idx_nxt = !bit_done ? bit_idx :
                    (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
  end

  // Line level is computed for the state being entered so the flop
  // changes on the same edge as the state.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_reg[bit_idx_nxt];
      PARITY:  tx_nxt = par_bit;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt    <= '0;
      bit_idx     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      ps_reg      <= '0;
      TX_OUT      <= 1'b1;
      Busy        <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      TX_OUT   <= tx_nxt;
      Busy     <= busy_nxt;
      if (state == IDLE && Data_Valid) begin
        data_reg    <= P_DATA;
        par_en_reg  <= PAR_EN;
        par_typ_reg <= PAR_TYP;
        ps_reg      <= Prescale;
      end
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter PRESCALE_BITS, default 5, width of the bit-period counter and the Prescale input.
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 P_DATA  input  DATA_WIDTH  parallel byte to transmit; sampled only on acceptance.
REQ-006 Data_Valid  input  1  transmit request; qualifies P_DATA.
REQ-007 PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
REQ-009 Prescale  input  PRESCALE_BITS  CLK cycles per serial bit; sampled on acceptance.
REQ-010 TX_OUT  output  1  serial line, registered, idle high.
REQ-011 Busy  output  1  registered, high while a frame is in progress.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE: TX_OUT=1, Busy=0.
REQ-014 In IDLE, Data_Valid=1 at a rising edge SHALL accept the request and latch P_DATA, PAR_EN, PAR_TYP and Prescale into internal registers. On that same edge: state->START, TX_OUT->0, Busy->1.
REQ-015 Data_Valid in any state other than IDLE SHALL be ignored; latched values SHALL NOT change mid-frame.
REQ-016 Each bit SHALL be held on TX_OUT for exactly Prescale CLK cycles.
  - Bit timing uses an internal counter edge_cnt, 0..Prescale-1.
  - edge_cnt clears at every bit boundary.
  - A latched Prescale of 0 SHALL behave as 1.
REQ-017 START SHALL drive 0 for one bit period, then go to DATA.
REQ-018 DATA SHALL shift out the latched byte LSB first, one bit per period.
  - An internal bit index counts 0..DATA_WIDTH-1.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP.
REQ-019 The parity bit SHALL be computed from the latched byte.
  - Even: XOR-reduce of data.
  - Odd: inverted XOR-reduce.
  - PARITY holds the bit for one period, then goes to STOP.
REQ-020 STOP SHALL drive 1 for one bit period, then go to IDLE.
  - Busy falls on the same edge that enters IDLE.
REQ-021 Frame length from the acceptance edge to the Busy-fall edge SHALL be (2 + DATA_WIDTH + PAR_EN) x Prescale cycles.
REQ-022 At least one IDLE cycle SHALL separate frames. A Data_Valid held high SHALL be accepted on the first IDLE edge after STOP, so the minimum line-high time between frames is Prescale+1 cycles.
REQ-023 TX_OUT SHALL be glitch-free, driven directly from a flop.
REQ-024 Busy SHALL be driven directly from a flop.

Reset
REQ-025 While RST=0: state=IDLE, TX_OUT=1, Busy=0, all counters and latched registers cleared.
REQ-026 Assertion of RST mid-frame SHALL abort the frame immediately (asynchronously). After release, the block SHALL stay in IDLE until a new Data_Valid.

Verification
REQ-027 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=8 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 8 cycles; Busy high 88 cycles.
REQ-028 Same stimulus with PAR_TYP=1 -> parity bit 1; all other bits and timing unchanged.
REQ-029 P_DATA=0x3C, PAR_EN=0, Prescale=4 -> 0,0,0,1,1,1,1,0,0,1 at 4 cycles per bit; Busy high 40 cycles; no parity slot.
REQ-030 Data_Valid pulsed with P_DATA=0xFF during a 0x00 frame -> pulse ignored; frame carries 0x00 with unchanged timing.
REQ-031 Data_Valid held high, Prescale=1, P_DATA=0x81, PAR_EN=0 -> back-to-back 10-cycle frames, each separated by exactly 1 IDLE cycle with TX_OUT=1.
REQ-032 RST asserted during DATA bit 3 -> TX_OUT=1 and Busy=0 immediately; after release, TX_OUT stays 1 until the next Data_Valid.
